// File: rtl/msi_snoop_arbiter_if.sv
// Bus bundle between two MSI snooping caches and the snoop arbiter.
// The arbiter takes the slave view; the cores/memory side drives the master view.
interface msi_snoop_arbiter_if;
  logic        req0;
  logic        req1;
  logic [1:0]  op0;
  logic [1:0]  op1;
  logic [10:0] addr0;
  logic [10:0] addr1;
  logic        snoop_found0;
  logic        snoop_found1;
  logic [1:0]  snoop_state0;
  logic [1:0]  snoop_state1;
  logic        mem_rdy;
  logic [1:0]  gnt;
  logic [1:0]  snoop_search;
  logic [1:0]  snoop_inval;
  logic [10:0] snoop_addr;
  logic        mem_re;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [1:0]  done;
  logic        c2c;

  modport master (
    output req0, req1, op0, op1, addr0, addr1,
    output snoop_found0, snoop_found1, snoop_state0, snoop_state1, mem_rdy,
    input  gnt, snoop_search, snoop_inval, snoop_addr,
    input  mem_re, mem_we, mem_addr, done, c2c
  );

  modport slave (
    input  req0, req1, op0, op1, addr0, addr1,
    input  snoop_found0, snoop_found1, snoop_state0, snoop_state1, mem_rdy,
    output gnt, snoop_search, snoop_inval, snoop_addr,
    output mem_re, mem_we, mem_addr, done, c2c
  );
endinterface

// File: rtl/msi_snoop_arbiter.sv
// Two-core MSI snoop bus arbiter: round-robin grant, one-cycle snoop of the
// other cache, optional dirty flush, memory read, invalidate, done pulse.
module msi_snoop_arbiter (
  input  logic              clk,
  input  logic              rst_n,
  msi_snoop_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SNOOP, FLUSH, MEM, INVAL, DONE} state_t;
  typedef enum logic [1:0] {OP_ILL = 2'b00, BUS_RD = 2'b01, BUS_RDX = 2'b10, BUS_UPGR = 2'b11} bus_op_t;

  localparam logic [1:0] BLK_MODIFIED = 2'b10;

  state_t      state;
  bus_op_t     op_q;
  logic        cur;       // index of the granted core
  logic        ptr;       // round-robin pointer: core favoured on a tie
  logic        found_q;   // other cache held a valid copy at snoop time
  logic [10:0] addr_q;
  logic [1:0]  gnt_q;
  logic [1:0]  search_q;
  logic [1:0]  inval_q;
  logic        mem_re_q;
  logic        mem_we_q;
  logic [1:0]  done_q;
  logic        c2c_q;

  logic        pick;
  logic [1:0]  pick_op;
  logic [10:0] pick_addr;
  logic        snp_found;
  logic [1:0]  snp_state;

  // Illegal encoding 2'b00 is serviced as a plain read.
  function automatic bus_op_t norm_op(input logic [1:0] op);
    return (op == 2'b00) ? BUS_RD : bus_op_t'(op);
  endfunction

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Arbitration choice and snoop response of the non-granted cache.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick      = 1'b0;
    pick_op   = bus.op0;
    pick_addr = bus.addr0;
    if (bus.req0 && bus.req1) pick = ptr;
    else                      pick = bus.req1;
    if (pick) begin
      pick_op   = bus.op1;
      pick_addr = bus.addr1;
    end
    snp_found = cur ? bus.snoop_found0 : bus.snoop_found1;
    snp_state = cur ? bus.snoop_state0 : bus.snoop_state1;
  end

  // Transaction FSM with all bus outputs registered.
  // NOTE: sequential state uses non-blocking assignments only; reset is async active-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= BUS_RD;
      cur      <= 1'b0;
      ptr      <= 1'b0;
      found_q  <= 1'b0;
      addr_q   <= '0;
      gnt_q    <= '0;
      search_q <= '0;
      inval_q  <= '0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= '0;
      c2c_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            cur      <= pick;
            op_q     <= norm_op(pick_op);
            addr_q   <= pick_addr;
            gnt_q    <= onehot(pick);
            search_q <= onehot(~pick);
            c2c_q    <= 1'b0;
            state    <= SNOOP;
          end
        end
        SNOOP: begin
          search_q <= '0;
          found_q  <= snp_found;
          if (snp_found && snp_state == BLK_MODIFIED) begin
            mem_we_q <= 1'b1;
            state    <= FLUSH;
          end else if (op_q == BUS_UPGR) begin
            inval_q  <= onehot(~cur);
            state    <= INVAL;
          end else begin
            mem_re_q <= 1'b1;
            state    <= MEM;
          end
        end
        FLUSH: begin
          if (bus.mem_rdy) begin
            mem_we_q <= 1'b0;
            c2c_q    <= 1'b1;
            if (op_q == BUS_RD) begin
              done_q <= gnt_q;
              state  <= DONE;
            end else begin
              inval_q <= onehot(~cur);
              state   <= INVAL;
            end
          end
        end
        MEM: begin
          if (bus.mem_rdy) begin
            mem_re_q <= 1'b0;
            if (op_q == BUS_RDX && found_q) begin
              inval_q <= onehot(~cur);
              state   <= INVAL;
            end else begin
              done_q <= gnt_q;
              state  <= DONE;
            end
          end
        end
        INVAL: begin
          inval_q <= '0;
          done_q  <= gnt_q;
          state   <= DONE;
        end
        DONE: begin
          done_q <= '0;
          gnt_q  <= '0;
          ptr    <= ~cur;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.snoop_search = search_q;
  assign bus.snoop_inval  = inval_q;
  assign bus.snoop_addr   = addr_q;
  assign bus.mem_re       = mem_re_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.done         = done_q;
  assign bus.c2c          = c2c_q;

endmodule

// File: tb/tb_msi_snoop_arbiter.sv
// Self-checking bench for msi_snoop_arbiter: table of single-core transactions
// plus hand-written arbitration, stall and reset sequences.
module tb_msi_snoop_arbiter;

  localparam logic [1:0] ST_INV = 2'b00;
  localparam logic [1:0] ST_SHR = 2'b01;
  localparam logic [1:0] ST_MOD = 2'b10;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_RDX  = 2'b10;
  localparam logic [1:0] OP_UPGR = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  msi_snoop_arbiter_if bus ();

  msi_snoop_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          core;
    logic [1:0]  op;
    logic [10:0] addr;
    logic        found;   // other cache holds a copy
    logic [1:0]  state;   // other cache's block state
    int          delay;   // cycles mem_rdy is held low per access
    logic        c2c;
    int          re_cyc;
    int          we_cyc;
    int          inval_cyc;
    int          lat;     // cycles from grant edge to done visible
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0;          bus.req1 = 1'b0;
    bus.op0 = OP_RD;          bus.op1 = OP_RD;
    bus.addr0 = '0;           bus.addr1 = '0;
    bus.snoop_found0 = 1'b0;  bus.snoop_found1 = 1'b0;
    bus.snoop_state0 = ST_INV; bus.snoop_state1 = ST_INV;
    bus.mem_rdy = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {bus.gnt, bus.snoop_search, bus.snoop_inval, bus.mem_re, bus.mem_we,
            bus.done, bus.c2c, bus.snoop_addr, bus.mem_addr};
  endfunction

  // One single-core transaction; the granted core's own snoop inputs carry a
  // dirty-copy decoy so the arbiter must look at the other cache.
  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] own;
    logic [1:0] other;
    logic [1:0] dn;
    logic       c2c_at;
    int re, we, srch, inv, lat, cnt, bad;
    own = (v.core != 0) ? 2'b10 : 2'b01;
    other = ~own;
    dn = '0; c2c_at = 1'b0;
    re = 0; we = 0; srch = 0; inv = 0; lat = 0; cnt = 0; bad = 0;
    @(negedge clk);
    if (v.core != 0) begin
      bus.req1 = 1'b1; bus.op1 = v.op; bus.addr1 = v.addr;
      bus.snoop_found0 = v.found; bus.snoop_state0 = v.state;
      bus.snoop_found1 = 1'b1;    bus.snoop_state1 = ST_MOD;
    end else begin
      bus.req0 = 1'b1; bus.op0 = v.op; bus.addr0 = v.addr;
      bus.snoop_found1 = v.found; bus.snoop_state1 = v.state;
      bus.snoop_found0 = 1'b1;    bus.snoop_state0 = ST_MOD;
    end
    bus.mem_rdy = 1'b0;
    for (int c = 0; c < 60 && dn == 2'b00; c++) begin
      @(negedge clk);
      lat++;
      if (bus.gnt !== own) bad++;
      if (bus.mem_re && bus.mem_we) bad++;
      if ((bus.snoop_search & bus.snoop_inval) != 2'b00) bad++;
      if (((bus.snoop_search | bus.snoop_inval) & own) != 2'b00) bad++;
      if (bus.snoop_search != 2'b00) begin
        srch++;
        if (bus.snoop_search !== other || bus.snoop_addr !== v.addr || bus.c2c !== 1'b0) bad++;
      end
      if (bus.snoop_inval != 2'b00) begin
        inv++;
        if (bus.snoop_inval !== other || bus.snoop_addr !== v.addr) bad++;
      end
      if (bus.mem_re) re++;
      if (bus.mem_we) we++;
      if ((bus.mem_re || bus.mem_we) && bus.mem_addr !== v.addr) bad++;
      if (bus.mem_re || bus.mem_we) begin
        bus.mem_rdy = (cnt == v.delay);
        cnt++;
      end else begin
        bus.mem_rdy = 1'b0;
      end
      if (bus.done != 2'b00) begin
        dn = bus.done;
        c2c_at = bus.c2c;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_rdy = 1'b0;
    check($sformatf("v%0d_done", idx), {30'd0, dn}, {30'd0, own});
    check($sformatf("v%0d_c2c", idx), {31'd0, c2c_at}, {31'd0, v.c2c});
    check($sformatf("v%0d_mem_re_cycles", idx), re, v.re_cyc);
    check($sformatf("v%0d_mem_we_cycles", idx), we, v.we_cyc);
    check($sformatf("v%0d_search_cycles", idx), srch, 1);
    check($sformatf("v%0d_inval_cycles", idx), inv, v.inval_cyc);
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_protocol_errors", idx), bad, 0);
    @(negedge clk);
    check($sformatf("v%0d_after_done_gnt_done", idx), {28'd0, bus.gnt, bus.done}, 32'd0);
  endtask

  // Both cores issue a clean BUS_RD together; checks completion order.
  task automatic both_rd_order(input string name, input logic [1:0] first);
    logic [1:0] order[2];
    int n, bad;
    n = 0; bad = 0;
    order[0] = '0; order[1] = '0;
    @(negedge clk);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.op0 = OP_RD; bus.op1 = OP_RD;
    bus.addr0 = 11'h010; bus.addr1 = 11'h020;
    bus.snoop_found0 = 1'b0; bus.snoop_found1 = 1'b0;
    bus.mem_rdy = 1'b1;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk);
      if (bus.mem_we) bad++;
      if (bus.done != 2'b00) begin
        order[n] = bus.done;
        n++;
        if (bus.done[0]) bus.req0 = 1'b0;
        if (bus.done[1]) bus.req1 = 1'b0;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_rdy = 1'b0;
    check({name, "_first"}, {30'd0, order[0]}, {30'd0, first});
    check({name, "_second"}, {30'd0, order[1]}, {30'd0, ~first});
    check({name, "_no_mem_we"}, bad, 0);
    @(negedge clk);
  endtask

  // Core0 BUS_RDX stalled by memory while core1 waits behind it.
  task automatic stall_with_pending();
    int re, cnt, bad;
    logic [1:0] dn;
    logic [1:0] g;
    re = 0; cnt = 0; bad = 0; dn = '0; g = '0;
    @(negedge clk);
    bus.req0 = 1'b1; bus.op0 = OP_RDX; bus.addr0 = 11'h1F0;
    bus.snoop_found1 = 1'b0; bus.snoop_state1 = ST_INV;
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    check("stall_grant0", {30'd0, bus.gnt}, 32'd1);
    bus.req1 = 1'b1; bus.op1 = OP_RD; bus.addr1 = 11'h00F;
    bus.snoop_found0 = 1'b0; bus.snoop_state0 = ST_INV;
    for (int c = 0; c < 40 && dn == 2'b00; c++) begin
      @(negedge clk);
      if (bus.gnt !== 2'b01) bad++;
      if (bus.mem_re) begin
        re++;
        bus.mem_rdy = (cnt == 5);
        cnt++;
      end else begin
        bus.mem_rdy = 1'b0;
      end
      if (bus.done != 2'b00) dn = bus.done;
    end
    bus.req0 = 1'b0;
    check("stall_mem_re_cycles", re, 6);
    check("stall_gnt_stable", bad, 0);
    check("stall_done0", {30'd0, dn}, 32'd1);
    for (int c = 0; c < 10 && g == 2'b00; c++) begin
      @(negedge clk);
      g = bus.gnt;
    end
    check("stall_then_grant1", {30'd0, g}, 32'd2);
    dn = '0;
    bus.mem_rdy = 1'b1;
    for (int c = 0; c < 20 && dn == 2'b00; c++) begin
      @(negedge clk);
      if (bus.done != 2'b00) dn = bus.done;
    end
    bus.req1 = 1'b0; bus.mem_rdy = 1'b0;
    check("stall_done1", {30'd0, dn}, 32'd2);
    @(negedge clk);
  endtask

  // Reset asserted while a read waits in MEM.
  task automatic reset_in_mem();
    logic seen;
    int dn_cnt;
    seen = 1'b0; dn_cnt = 0;
    @(negedge clk);
    bus.req0 = 1'b1; bus.op0 = OP_RD; bus.addr0 = 11'h2AA;
    bus.snoop_found1 = 1'b0; bus.mem_rdy = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.mem_re;
    end
    check("rst_reached_mem", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1;
    check("rst_outputs_async_zero", all_outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.done != 2'b00 || bus.gnt != 2'b00) dn_cnt++;
    end
    check("rst_no_done_or_gnt", dn_cnt, 0);
  endtask

  initial begin
    vecs[0] = '{0, OP_RD,   11'h123, 1'b0, ST_INV, 0, 1'b0, 1, 0, 0, 3};
    vecs[1] = '{1, OP_RD,   11'h2A5, 1'b1, ST_MOD, 2, 1'b1, 0, 3, 0, 5};
    vecs[2] = '{0, OP_UPGR, 11'h041, 1'b1, ST_SHR, 0, 1'b0, 0, 0, 1, 3};
    vecs[3] = '{1, OP_UPGR, 11'h7FF, 1'b0, ST_INV, 0, 1'b0, 0, 0, 1, 3};
    vecs[4] = '{0, OP_RDX,  11'h555, 1'b1, ST_SHR, 1, 1'b0, 2, 0, 1, 5};
    vecs[5] = '{1, OP_RDX,  11'h0AA, 1'b1, ST_MOD, 0, 1'b1, 0, 1, 1, 4};
    vecs[6] = '{0, 2'b00,   11'h3C3, 1'b1, ST_MOD, 1, 1'b1, 0, 2, 0, 4};
    vecs[7] = '{1, OP_RD,   11'h18C, 1'b1, ST_SHR, 3, 1'b0, 4, 0, 0, 6};
    vecs[8] = '{0, OP_RDX,  11'h600, 1'b0, ST_INV, 0, 1'b0, 1, 0, 0, 3};
    vecs[9] = '{0, OP_RD,   11'h001, 1'b0, ST_MOD, 0, 1'b0, 1, 0, 0, 3};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_outputs_zero", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_idle", all_outs(), 32'd0);

    both_rd_order("rr_from_reset", 2'b01);
    stall_with_pending();
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    // Last vector granted core0, so the pointer now favours core1.
    both_rd_order("rr_ptr_core1", 2'b10);
    reset_in_mem();
    both_rd_order("rr_after_reset", 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/msi_snoop_arbiter.md
MSI_SNOOP_ARBITER -- requirements
Module: msi_snoop_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports req0/req1  input  1  per-core bus request, held high until matching done pulse.
REQ-004 SHALL have ports op0/op1  input  2  bus op: 2'b01 BUS_RD, 2'b10 BUS_RDX, 2'b11 BUS_UPGR; 2'b00 illegal, treated as BUS_RD.
REQ-005 SHALL have ports addr0/addr1  input  11  block address {tag[4:0],index[5:0]}.
REQ-006 SHALL have ports snoop_found0/snoop_found1  input  1  other cache holds a valid copy (cpu_search_found).
REQ-007 SHALL have ports snoop_state0/snoop_state1  input  2  blk_state_t of snooped copy (INVALID, SHARED, MODIFIED).
REQ-008 SHALL have port mem_rdy  input  1  memory completes current access this cycle.
REQ-009 SHALL have port gnt  output  2  one-hot grant (bit0 core0, bit1 core1).
REQ-010 SHALL have port snoop_search  output  2  cpu_search strobe to the non-granted core's cache.
REQ-011 SHALL have port snoop_inval  output  2  invalidate_from_other_cpu strobe to the non-granted core's cache.
REQ-012 SHALL have port snoop_addr  output  11  BOCI address; equals granted core's latched address.
REQ-013 SHALL have ports mem_re/mem_we  output  1  memory read / write-back strobes, held until mem_rdy.
REQ-014 SHALL have port mem_addr  output  11  memory address; latched granted address.
REQ-015 SHALL have port done  output  2  one-cycle completion pulse to granted core.
REQ-016 SHALL have port c2c  output  1  high with done when data sourced from the other cache's flush.

Function
REQ-017 SHALL implement FSM states IDLE, SNOOP, FLUSH, MEM, INVAL, DONE.
REQ-018 IDLE: if any req, SHALL grant per round-robin pointer, latch op/addr, assert gnt, go to SNOOP next cycle.
REQ-019 Round-robin: pointer SHALL point to core not last granted; both req -> pointed core wins; single req wins regardless of pointer.
REQ-020 SNOOP (1 cycle): snoop_search to other core high, snoop_addr valid; sample snoop_found/snoop_state at end of cycle.
REQ-021 From SNOOP: found && state MODIFIED -> FLUSH; else op BUS_UPGR -> INVAL (skip memory); else -> MEM.
REQ-022 FLUSH: mem_we high, mem_addr = latched addr, until mem_rdy; then c2c flag set; op BUS_RD -> DONE (skip MEM read), op BUS_RDX -> INVAL.
REQ-023 MEM: mem_re high until mem_rdy; then op BUS_RDX and found -> INVAL; else -> DONE.
REQ-024 INVAL (1 cycle): snoop_inval to other core high with snoop_addr; BUS_RD never enters INVAL; -> DONE.
REQ-025 DONE (1 cycle): done bit of granted core high, c2c valid; gnt drops; pointer updates; -> IDLE.
REQ-026 Minimum latency req to done: BUS_UPGR no copy = 3 cycles (grant edge, SNOOP, INVAL... DONE); MEM with mem_rdy same cycle = 3 cycles after grant.
REQ-027 gnt SHALL remain constant from grant through DONE; req changes mid-transaction SHALL be ignored.
REQ-028 Deassertion of granted req before done SHALL NOT abort the transaction.
REQ-029 mem_re and mem_we SHALL never be high together; snoop_search and snoop_inval never high together.
REQ-030 Snoop strobes SHALL target only the non-granted core; granted core's snoop bits always 0.
REQ-031 c2c SHALL clear on entering SNOOP.

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, gnt=0, snoop_search=0, snoop_inval=0, mem_re=0, mem_we=0, done=0, c2c=0, snoop_addr=0, mem_addr=0, pointer=core0.
REQ-033 Reset mid-transaction SHALL drop all strobes immediately; no done pulse issued for aborted transaction.

Verification
REQ-034 Both req high from reset, op=BUS_RD, no copies, mem_rdy=1 -> core0 done first, then core1 granted; order 0,1.
REQ-035 Core1 BUS_RD addr 11'h2A5, core0 holds MODIFIED -> snoop_search=2'b01 with snoop_addr=11'h2A5, mem_we until mem_rdy, done=2'b10 with c2c=1, no mem_re.
REQ-036 Core0 BUS_UPGR addr 11'h041, core1 SHARED -> SNOOP, INVAL with snoop_inval=2'b10, done=2'b01; mem_re/mem_we never high.
REQ-037 Core0 BUS_RDX, mem_rdy held low 5 cycles -> mem_re high 5+1 cycles, gnt stable 2'b01, core1 req pending not granted until after done.
REQ-038 rst_n pulsed low during MEM -> all outputs 0 same cycle, FSM IDLE, pointer core0, no done.
